vec_decode_stage: RTL and testbench

VEC_DECODE_STAGE -- requirements
Module: vec_decode_stage

---
 rtl/vec_decode_stage.sv | 163 ++++++++++++++++
 tb/tb_vec_decode_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vec_decode_stage.sv
// Vector decode stage: 16-entry vector register file, immediate extension and the
// decode/execute pipeline register with valid/ready handshake. Optional macro:
// DECODE_BYPASS_EN enables same-cycle write-through from writeback to the read ports.
module vec_decode_stage #(
   parameter int unsigned N     = 8,
   parameter int unsigned LANES = 16
) (
   input  logic                      clk,
   input  logic                      RST,
   input  logic [27:0]               Instr,
   input  logic                      instr_valid,
   output logic                      instr_ready,
   input  logic [1:0]                RegSrc,
   input  logic                      ImmSrcD,
   input  logic                      RegWriteW,
   input  logic [3:0]                wa3w,
   input  logic [LANES-1:0][N-1:0]   wd3,
   input  logic                      flushE,
   input  logic                      ex_ready,
   output logic                      ex_valid,
   output logic [LANES-1:0][N-1:0]   rd1E,
   output logic [LANES-1:0][N-1:0]   rd2E,
   output logic [LANES-1:0][N-1:0]   ExtImmE,
   output logic [3:0]                ra1E,
   output logic [3:0]                ra2E,
   output logic [3:0]                wa3E
);

   localparam int unsigned ExtW = (N > 10) ? N : 10;

   logic [LANES-1:0][N-1:0] rf_q [16];
   logic [LANES-1:0][N-1:0] rf_d [16];

   logic [3:0]              ra1;
   logic [3:0]              ra2;
   logic [3:0]              wa3;
   logic [9:0]              imm10;
   logic [ExtW-1:0]         imm_ext;
   logic [LANES-1:0][N-1:0] ext_imm;
   logic [LANES-1:0][N-1:0] rd1;
   logic [LANES-1:0][N-1:0] rd2;
   logic                    load;

   logic                    ex_valid_q, ex_valid_d;
   logic [LANES-1:0][N-1:0] rd1_q, rd1_d;
   logic [LANES-1:0][N-1:0] rd2_q, rd2_d;
   logic [LANES-1:0][N-1:0] ext_imm_q, ext_imm_d;
   logic [3:0]              ra1_q, ra1_d;
   logic [3:0]              ra2_q, ra2_d;
   logic [3:0]              wa3_q, wa3_d;

   // Instr[17:16] carry no field for this stage.
   logic unused_instr;
   assign unused_instr = ^Instr[17:16];

   // Operand address selection.
   always_comb begin
      ra1   = RegSrc[0] ? 4'hF : Instr[3:0];
      ra2   = RegSrc[1] ? Instr[7:4] : Instr[11:8];
      wa3   = Instr[15:12];
      imm10 = Instr[27:18];
   end

   // Extend imm10 to at least 10 bits, then keep the low N bits for each lane.
   always_comb begin
      imm_ext = '0;
      for (int unsigned i = 0; i < 10; i++) begin
         imm_ext[i] = imm10[i];
      end
      for (int unsigned i = 10; i < ExtW; i++) begin
         imm_ext[i] = ImmSrcD & imm10[9];
      end
      for (int unsigned l = 0; l < LANES; l++) begin
         ext_imm[l] = imm_ext[N-1:0];
      end
   end

   // Register file read ports.
   always_comb begin
`ifdef DECODE_BYPASS_EN
      rd1 = (RegWriteW && (wa3w == ra1)) ? wd3 : rf_q[ra1];
      rd2 = (RegWriteW && (wa3w == ra2)) ? wd3 : rf_q[ra2];
`else
      rd1 = rf_q[ra1];
      rd2 = rf_q[ra2];
`endif
   end

   // Writeback is independent of stall, flush and instr_valid; r15 is ordinary.
   always_comb begin
      rf_d = rf_q;
      if (RegWriteW) begin
         rf_d[wa3w] = wd3;
      end
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         for (int i = 0; i < 16; i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         rf_q <= rf_d;
      end
   end

   // RST gates ready so nothing is accepted while the stage is held in reset.
   assign instr_ready = (!ex_valid_q || ex_ready) && !flushE && !RST;
   assign load        = instr_valid && instr_ready;

   // Decode/execute register next state: flush > load > drain > hold.
   always_comb begin
      ex_valid_d = ex_valid_q;
      rd1_d      = rd1_q;
      rd2_d      = rd2_q;
      ext_imm_d  = ext_imm_q;
      ra1_d      = ra1_q;
      ra2_d      = ra2_q;
      wa3_d      = wa3_q;
      if (flushE) begin
         ex_valid_d = 1'b0;
      end else if (load) begin
         ex_valid_d = 1'b1;
         rd1_d      = rd1;
         rd2_d      = rd2;
         ext_imm_d  = ext_imm;
         ra1_d      = ra1;
         ra2_d      = ra2;
         wa3_d      = wa3;
      end else if (ex_valid_q && ex_ready) begin
         ex_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         ex_valid_q <= 1'b0;
         rd1_q      <= '0;
         rd2_q      <= '0;
         ext_imm_q  <= '0;
         ra1_q      <= '0;
         ra2_q      <= '0;
         wa3_q      <= '0;
      end else begin
         ex_valid_q <= ex_valid_d;
         rd1_q      <= rd1_d;
         rd2_q      <= rd2_d;
         ext_imm_q  <= ext_imm_d;
         ra1_q      <= ra1_d;
         ra2_q      <= ra2_d;
         wa3_q      <= wa3_d;
      end
   end

   assign ex_valid = ex_valid_q;
   assign rd1E     = rd1_q;
   assign rd2E     = rd2_q;
   assign ExtImmE  = ext_imm_q;
   assign ra1E     = ra1_q;
   assign ra2E     = ra2_q;
   assign wa3E     = wa3_q;

endmodule

// File: tb/tb_vec_decode_stage.sv
// Bench for vec_decode_stage: directed scenarios plus randomized traffic checked
// against a behavioural model of the register file and decode/execute register.
module tb_vec_decode_stage;

   localparam int unsigned N     = 8;
   localparam int unsigned LANES = 16;
   localparam int unsigned W     = N * LANES;

   logic                    clk = 1'b0;
   logic                    RST;
   logic [27:0]             Instr;
   logic                    instr_valid;
   logic                    instr_ready;
   logic [1:0]              RegSrc;
   logic                    ImmSrcD;
   logic                    RegWriteW;
   logic [3:0]              wa3w;
   logic [LANES-1:0][N-1:0] wd3;
   logic                    flushE;
   logic                    ex_ready;
   logic                    ex_valid;
   logic [LANES-1:0][N-1:0] rd1E;
   logic [LANES-1:0][N-1:0] rd2E;
   logic [LANES-1:0][N-1:0] ExtImmE;
   logic [3:0]              ra1E;
   logic [3:0]              ra2E;
   logic [3:0]              wa3E;

   int checks   = 0;
   int failures = 0;

   // Reference state
   logic [W-1:0] m_rf [16];
   logic         m_ev;
   logic [W-1:0] m_rd1, m_rd2, m_imm;
   logic [3:0]   m_ra1, m_ra2, m_wa3;

   logic [W-1:0] held;

   always #5 clk = ~clk;

   vec_decode_stage #(.N(N), .LANES(LANES)) dut (
      .clk         (clk),
      .RST         (RST),
      .Instr       (Instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .RegSrc      (RegSrc),
      .ImmSrcD     (ImmSrcD),
      .RegWriteW   (RegWriteW),
      .wa3w        (wa3w),
      .wd3         (wd3),
      .flushE      (flushE),
      .ex_ready    (ex_ready),
      .ex_valid    (ex_valid),
      .rd1E        (rd1E),
      .rd2E        (rd2E),
      .ExtImmE     (ExtImmE),
      .ra1E        (ra1E),
      .ra2E        (ra2E),
      .wa3E        (wa3E)
   );

   task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] m_read(input logic [3:0] a);
`ifdef DECODE_BYPASS_EN
      if (RegWriteW && (wa3w == a)) return wd3;
`endif
      return m_rf[a];
   endfunction

   function automatic logic [W-1:0] m_imm_of(input logic [9:0] imm, input logic sgn);
      int v;
      logic [N-1:0] e;
      v = int'(imm);
      if (sgn && (imm >= 10'd512)) v = v - 1024;
      e = N'(v);
      return {LANES{e}};
   endfunction

   // One clock: check ready mid-cycle, advance the model, check outputs after the edge.
   task automatic cycle();
      logic         exp_ready;
      logic         load;
      logic [3:0]   a1, a2;
      logic [W-1:0] r1, r2, im;
      @(negedge clk);
      exp_ready = !RST && !flushE && (!m_ev || ex_ready);
      check_eq("instr_ready", W'(instr_ready), W'(exp_ready));
      load = instr_valid && exp_ready;
      a1   = RegSrc[0] ? 4'hF : Instr[3:0];
      a2   = RegSrc[1] ? Instr[7:4] : Instr[11:8];
      r1   = m_read(a1);
      r2   = m_read(a2);
      im   = m_imm_of(Instr[27:18], ImmSrcD);
      @(posedge clk);
      #1;
      if (RST) begin
         for (int i = 0; i < 16; i++) m_rf[i] = '0;
         m_ev  = 1'b0;
         m_rd1 = '0;
         m_rd2 = '0;
         m_imm = '0;
         m_ra1 = '0;
         m_ra2 = '0;
         m_wa3 = '0;
      end else begin
         if (flushE) begin
            m_ev = 1'b0;
         end else if (load) begin
            m_ev  = 1'b1;
            m_rd1 = r1;
            m_rd2 = r2;
            m_imm = im;
            m_ra1 = a1;
            m_ra2 = a2;
            m_wa3 = Instr[15:12];
         end else if (m_ev && ex_ready) begin
            m_ev = 1'b0;
         end
         if (RegWriteW) m_rf[wa3w] = wd3;
      end
      check_eq("ex_valid", W'(ex_valid), W'(m_ev));
      check_eq("rd1E", rd1E, m_rd1);
      check_eq("rd2E", rd2E, m_rd2);
      check_eq("ExtImmE", ExtImmE, m_imm);
      check_eq("ra1E", W'(ra1E), W'(m_ra1));
      check_eq("ra2E", W'(ra2E), W'(m_ra2));
      check_eq("wa3E", W'(wa3E), W'(m_wa3));
   endtask

   initial begin
      for (int i = 0; i < 16; i++) m_rf[i] = '0;
      m_ev = 1'b0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
      m_ra1 = '0; m_ra2 = '0; m_wa3 = '0;
      RST = 1'b1; Instr = '0; instr_valid = 1'b0; RegSrc = '0; ImmSrcD = 1'b0;
      RegWriteW = 1'b0; wa3w = '0; wd3 = '0; flushE = 1'b0; ex_ready = 1'b1;
      cycle();
      RST = 1'b0;
      check_eq("reset_ex_valid", W'(ex_valid), W'(0));
      check_eq("reset_rd1E", rd1E, W'(0));

      // Write r3, then read it through rn.
      RegWriteW = 1'b1; wa3w = 4'd3; wd3 = {LANES{8'h5A}};
      cycle();
      RegWriteW = 1'b0; Instr = 28'h0000003; RegSrc = 2'b00; instr_valid = 1'b1;
      cycle();
      check_eq("r3_ex_valid", W'(ex_valid), W'(1));
      check_eq("r3_rd1E", rd1E, {LANES{8'h5A}});
      check_eq("r3_ra1E", W'(ra1E), W'(3));

      // Immediate extension.
      Instr = {10'h3F0, 18'h0}; ImmSrcD = 1'b1;
      cycle();
      check_eq("imm_sext", ExtImmE, {LANES{8'hF0}});
      Instr = {10'h005, 18'h0}; ImmSrcD = 1'b0;
      cycle();
      check_eq("imm_zext", ExtImmE, {LANES{8'h05}});

      // Writeback vs read of the same register in one cycle.
      instr_valid = 1'b0; RegWriteW = 1'b1; wa3w = 4'd4; wd3 = {LANES{8'h22}};
      cycle();
      Instr = 28'h0000004; instr_valid = 1'b1; wd3 = {LANES{8'h11}};
      cycle();
`ifdef DECODE_BYPASS_EN
      check_eq("bypass_rd1E", rd1E, {LANES{8'h11}});
`else
      check_eq("bypass_rd1E", rd1E, {LANES{8'h22}});
`endif

      // Stall three cycles while r4 keeps being rewritten; E must not refresh.
      held = rd1E;
      ex_ready = 1'b0; Instr = 28'h0000005;
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < LANES; i++) wd3[i] = N'($urandom);
         cycle();
         check_eq("stall_rd1E", rd1E, held);
         check_eq("stall_ra1E", W'(ra1E), W'(4));
      end
      RegWriteW = 1'b0; ex_ready = 1'b1;
      cycle();
      check_eq("unstall_ra1E", W'(ra1E), W'(5));

      // Flush wins over a valid instruction.
      flushE = 1'b1; Instr = 28'h0000006;
      cycle();
      check_eq("flush_ex_valid", W'(ex_valid), W'(0));
      check_eq("flush_ra1E", W'(ra1E), W'(5));
      flushE = 1'b0;

      // Reset in the middle of a stall.
      ex_ready = 1'b0; Instr = 28'h0000007;
      cycle();
      cycle();
      RST = 1'b1;
      cycle();
      RST = 1'b0;
      check_eq("rst_ex_valid", W'(ex_valid), W'(0));
      check_eq("rst_rd1E", rd1E, W'(0));
      check_eq("rst_ra1E", W'(ra1E), W'(0));

      // Randomized traffic.
      for (int c = 0; c < 600; c++) begin
         RST         = ($urandom_range(0, 49) == 0);
         Instr       = 28'($urandom);
         instr_valid = 1'($urandom);
         RegSrc      = 2'($urandom);
         ImmSrcD     = 1'($urandom);
         RegWriteW   = 1'($urandom);
         wa3w        = 4'($urandom);
         for (int i = 0; i < LANES; i++) wd3[i] = N'($urandom);
         flushE      = ($urandom_range(0, 7) == 0);
         ex_ready    = ($urandom_range(0, 3) != 0);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
